// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector multiply output path.
//   DEF_IN_W / DEF_OUT_W : default sample widths (signed 16-bit in, signed 8-bit out)
//   OUT_MAX / OUT_MIN    : saturation limits of the signed output sample
//   fifo_entry_t         : one buffered result {last-of-vector flag, sample}
package mvm_pkg;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 8;

    localparam int OUT_MAX = (1 << (DEF_OUT_W - 1)) - 1;
    localparam int OUT_MIN = -(1 << (DEF_OUT_W - 1));

    typedef struct packed {
        logic                        last;
        logic signed [DEF_OUT_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/mvm_out_requant_if.sv
// Stream bundle between the multiplier, the requant stage and the next layer.
//   s_valid/s_ready/data_in   : upstream 16-bit results into the requant stage
//   m_valid/m_ready/data_out  : requantized 8-bit samples out of the stage
//   m_last                    : data_out is the final element of its vector
// Handshake: a beat transfers on a rising clk edge where valid && ready; the
// sender holds its payload stable while valid is high and ready is low.
// master = the environment around the stage, slave = the requant stage.
interface mvm_out_requant_if
    import mvm_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
);
    logic                    s_valid;
    logic                    s_ready;
    logic signed [IN_W-1:0]  data_in;
    logic                    m_valid;
    logic                    m_ready;
    logic signed [OUT_W-1:0] data_out;
    logic                    m_last;

    modport master (
        output s_valid, data_in, m_ready,
        input  s_ready, m_valid, data_out, m_last
    );

    modport slave (
        input  s_valid, data_in, m_ready,
        output s_ready, m_valid, data_out, m_last
    );
endinterface

// File: rtl/mvm_out_requant_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, no bypass.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push, pop  : requests; push is ignored when full, pop when empty
//   wr_data    : entry written on push
//   rd_data    : head entry, forced to 0 when empty
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
module sync_fifo
    import mvm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/mvm_out_requant.sv
// Requantizes the multiplier's signed 16-bit results to signed 8-bit:
// optional ReLU, rounding arithmetic right shift, saturation. Tags the last
// element of each VEC_LEN vector and buffers results in a small FIFO so
// output backpressure does not stall the multiplier.
//   clk, reset : clock, synchronous active-high reset
//   bus        : stream bundle (slave side), see mvm_out_requant_if
//   sat_cnt    : number of saturated samples accepted, sticks at 255
//   dbg_count  : current FIFO occupancy
// The FIFO entry layout comes from mvm_pkg, so OUT_W must match DEF_OUT_W.
module mvm_out_requant
    import mvm_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int VEC_LEN = 3,
    parameter int SHIFT   = 4,
    parameter int RELU    = 1,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    mvm_out_requant_if.slave       bus,
    output logic [7:0]             sat_cnt,
    output logic [$clog2(DEPTH):0] dbg_count
);
    localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic signed [IN_W:0] RND   = (IN_W+1)'(1 << (SHIFT - 1));
    localparam logic signed [IN_W:0] Q_MAX = (IN_W+1)'(OUT_MAX);
    localparam logic signed [IN_W:0] Q_MIN = (IN_W+1)'(OUT_MIN);

    logic signed [IN_W-1:0]  relu_val;
    logic signed [IN_W:0]    rounded;
    logic signed [IN_W:0]    shifted;
    logic signed [OUT_W-1:0] clamped;
    logic                    sat;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       sat_cnt_q, sat_cnt_d;
    logic             push, pop, fifo_full, fifo_empty;
    fifo_entry_t      wr_entry, rd_entry;

    // Rounding add is done one bit wider so 32767 + half-LSB cannot wrap.
    always_comb begin
        relu_val = bus.data_in;
        if (RELU != 0 && bus.data_in < 0) relu_val = '0;
        rounded = (IN_W+1)'(relu_val) + RND;
        shifted = rounded >>> SHIFT;
        clamped = shifted[OUT_W-1:0];
        sat     = 1'b0;
        if (shifted > Q_MAX) begin
            clamped = Q_MAX[OUT_W-1:0];
            sat     = 1'b1;
        end else if (shifted < Q_MIN) begin
            clamped = Q_MIN[OUT_W-1:0];
            sat     = 1'b1;
        end
    end

    assign push = bus.s_valid && bus.s_ready;
    assign pop  = bus.m_valid && bus.m_ready;

    always_comb begin
        idx_d     = idx_q;
        sat_cnt_d = sat_cnt_q;
        if (push) begin
            idx_d = (idx_q == IDX_W'(VEC_LEN - 1)) ? '0 : idx_q + IDX_W'(1);
            if (sat && sat_cnt_q != 8'hFF) sat_cnt_d = sat_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= '0;
            sat_cnt_q <= '0;
        end else begin
            idx_q     <= idx_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    always_comb begin
        wr_entry      = '0;
        wr_entry.last = (idx_q == IDX_W'(VEC_LEN - 1));
        wr_entry.data = clamped;
    end

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (dbg_count)
    );

    // Not ready while reset is asserted, so nothing is accepted during a flush.
    assign bus.s_ready  = !fifo_full && !reset;
    assign bus.m_valid  = !fifo_empty;
    assign bus.data_out = rd_entry.data;
    assign bus.m_last   = rd_entry.last;
    assign sat_cnt      = sat_cnt_q;
endmodule
